// File: rtl/memoria_pkg.sv
// Shared types and helpers for the dual-port data memory: arbiter states,
// default geometry and the byte parity function used when MEMORIA_PARIDAD_EN is set.
package memoria_pkg;

  typedef enum logic [1:0] {
    LIBRE   = 2'd0,
    ESPERA  = 2'd1,
    FORZADO = 2'd2
  } estado_arb_t;

  localparam int ANCHO_DEF       = 32;
  localparam int PROFUNDIDAD_DEF = 1024;
  localparam int MAX_ESPERA_DEF  = 4;

  // Even parity: the stored bit makes the total count of ones in byte+bit even.
  function automatic logic paridad_byte(input logic [7:0] dato);
    return ^dato;
  endfunction

endpackage

// File: rtl/memoria_arbitro.sv
// Two-port arbiter: port A has priority, port B is forced a grant after
// MAX_ESPERA consecutive lost cycles.
module memoria_arbitro
  import memoria_pkg::*;
#(
  parameter int MAX_ESPERA = MAX_ESPERA_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic a_req_i,
  input  logic b_req_i,
  output logic a_listo_o,
  output logic b_listo_o,
  output logic sel_b_o
);

  localparam int CW = $clog2(MAX_ESPERA + 2);

  estado_arb_t   estado_q, estado_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the values from before the edge, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado_q <= LIBRE;
      cnt_q    <= '0;
    end else begin
      estado_q <= estado_d;
      cnt_q    <= cnt_d;
    end
  end

  // NOTE: every signal driven here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    estado_d = estado_q;
    cnt_d    = cnt_q;
    if (!b_req_i || b_listo_o) begin
      estado_d = LIBRE;
      cnt_d    = '0;
    end else begin
      cnt_d    = cnt_q + 1'b1;
      estado_d = (cnt_d >= CW'(MAX_ESPERA)) ? FORZADO : ESPERA;
    end
  end

  // Grants are held low during reset so nothing is accepted while rst_n=0.
  always_comb begin
    a_listo_o = 1'b0;
    b_listo_o = 1'b0;
    sel_b_o   = 1'b0;
    if (rst_n) begin
      if (estado_q == FORZADO) begin
        b_listo_o = b_req_i;
        sel_b_o   = 1'b1;
      end else if (a_req_i) begin
        a_listo_o = 1'b1;
      end else if (b_req_i) begin
        b_listo_o = 1'b1;
        sel_b_o   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/memoria_datos_2p.sv
// Dual-port (CPU/DMA) byte-writable data memory with one access per cycle.
// Optional per-byte even parity is enabled with `define MEMORIA_PARIDAD_EN.
module memoria_datos_2p
  import memoria_pkg::*;
#(
  parameter int ANCHO       = ANCHO_DEF,
  parameter int PROFUNDIDAD = PROFUNDIDAD_DEF,
  parameter int MAX_ESPERA  = MAX_ESPERA_DEF
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [31:0]        a_direccion,
  input  logic [31:0]        b_direccion,
  input  logic [ANCHO-1:0]   a_dato_entrada,
  input  logic [ANCHO-1:0]   b_dato_entrada,
  input  logic [ANCHO/8-1:0] a_be,
  input  logic [ANCHO/8-1:0] b_be,
  input  logic               a_escritura,
  input  logic               b_escritura,
  input  logic               a_lectura,
  input  logic               b_lectura,
`ifdef MEMORIA_PARIDAD_EN
  input  logic               a_inv_par,
`endif
  output logic               a_listo,
  output logic               b_listo,
  output logic [ANCHO-1:0]   a_dato_salida,
  output logic [ANCHO-1:0]   b_dato_salida,
  output logic               a_valido,
  output logic               b_valido,
  output logic               a_error,
  output logic               b_error
);

  localparam int NB = ANCHO / 8;
  localparam int AW = (PROFUNDIDAD > 1) ? $clog2(PROFUNDIDAD) : 1;

  logic             sel_b;
  logic [31:0]      dir;
  logic [ANCHO-1:0] din;
  logic [NB-1:0]    be;
  logic             esc, lec;
  logic             acepta, en_rango, wr_en, rd_en, par_err, err_acc;
  logic [AW-1:0]    idx;
  logic [ANCHO-1:0] rd_dato;

  memoria_arbitro #(
    .MAX_ESPERA (MAX_ESPERA)
  ) u_arbitro (
    .clk       (clk),
    .rst_n     (reset_n),
    .a_req_i   (a_escritura | a_lectura),
    .b_req_i   (b_escritura | b_lectura),
    .a_listo_o (a_listo),
    .b_listo_o (b_listo),
    .sel_b_o   (sel_b)
  );

  always_comb begin
    dir = sel_b ? b_direccion    : a_direccion;
    din = sel_b ? b_dato_entrada : a_dato_entrada;
    be  = sel_b ? b_be           : a_be;
    esc = sel_b ? b_escritura    : a_escritura;
    lec = sel_b ? b_lectura      : a_lectura;
  end

  // Write-plus-read on one port is a plain write with no read data returned.
  assign en_rango = dir < 32'(PROFUNDIDAD);
  assign idx      = dir[AW-1:0];
  assign acepta   = a_listo | b_listo;
  assign wr_en    = acepta & esc & en_rango;
  assign rd_en    = acepta & lec & ~esc;

  logic [ANCHO-1:0] mem [PROFUNDIDAD];

  // NOTE: the storage array has no reset; contents survive reset and this
  // keeps it mappable onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < NB; i++) begin
        if (be[i]) mem[idx][8*i +: 8] <= din[8*i +: 8];
      end
    end
  end

`ifdef MEMORIA_PARIDAD_EN
  logic [NB-1:0] par_mem [PROFUNDIDAD];
  logic          inv_par;

  assign inv_par = a_inv_par & ~sel_b;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < NB; i++) begin
        if (be[i]) par_mem[idx][i] <= paridad_byte(din[8*i +: 8]) ^ inv_par;
      end
    end
  end

  always_comb begin
    par_err = 1'b0;
    for (int i = 0; i < NB; i++) begin
      par_err = par_err | (paridad_byte(mem[idx][8*i +: 8]) ^ par_mem[idx][i]);
    end
  end
`else
  assign par_err = 1'b0;
`endif

  assign rd_dato = en_rango ? mem[idx] : '0;
  assign err_acc = ~en_rango | (rd_en & par_err);

  // Per-port response registers, index 0 = port A, 1 = port B.
  logic [1:0]            listo;
  logic [1:0][ANCHO-1:0] dato_q, dato_d;
  logic [1:0]            valido_q, valido_d;
  logic [1:0]            error_q, error_d;

  assign listo = {b_listo, a_listo};

  always_comb begin
    dato_d   = dato_q;
    valido_d = '0;
    error_d  = '0;
    for (int p = 0; p < 2; p++) begin
      valido_d[p] = listo[p] & rd_en;
      error_d[p]  = listo[p] & err_acc;
      if (listo[p] & rd_en) dato_d[p] = rd_dato;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dato_q   <= '0;
      valido_q <= '0;
      error_q  <= '0;
    end else begin
      dato_q   <= dato_d;
      valido_q <= valido_d;
      error_q  <= error_d;
    end
  end

  assign a_dato_salida = dato_q[0];
  assign b_dato_salida = dato_q[1];
  assign a_valido      = valido_q[0];
  assign b_valido      = valido_q[1];
  assign a_error       = error_q[0];
  assign b_error       = error_q[1];

endmodule
